// File: rtl/fetch.sv
// Instruction fetch stage. A one-cycle start pulse selects the fetch address
// (sequential PC or taken-branch redirect), issues one read to a synchronous
// instruction ROM with fixed latency, captures the returned word and presents
// pc/instr_raw to decode with the enabled/completed handshake.
module fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_AW     = 14,
  parameter int unsigned MEM_LATENCY = 1   // legal range 1..4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enabled,
  input  logic               branch_taken,
  input  logic [31:0]        branch_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        instr_raw,
  output logic               completed
);

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_next_q, pc_next_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               imem_en_q, imem_en_d;
  logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [31:0]        fetch_addr;

  // Redirect targets are forced word-aligned; the ROM only sees the low
  // IMEM_AW word-address bits, so higher addresses alias silently.
  assign fetch_addr = branch_taken ? {branch_pc[31:2], 2'b00} : pc_next_q;

  logic unused_bits;
  assign unused_bits = ^{branch_pc[1:0], fetch_addr[31:IMEM_AW+2], fetch_addr[1:0]};

  // State register and all datapath registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      pc_next_q   <= RESET_PC;
      pc_q        <= 32'h0000_0000;
      instr_q     <= NOP;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
      done_q      <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_next_q   <= pc_next_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
      done_q      <= done_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  // Next-state and datapath update logic.
  // NOTE: every signal gets a hold default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_next_d   = pc_next_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_en_d   = imem_en_q;
    imem_addr_d = imem_addr_q;
    done_d      = done_q;
    lat_cnt_d   = lat_cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (enabled) begin
          pc_d        = fetch_addr;
          pc_next_d   = fetch_addr + 32'd4;
          imem_addr_d = fetch_addr[IMEM_AW+1:2];
          imem_en_d   = 1'b1;
          done_d      = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // The ROM samples the address on this edge; the strobe is one cycle.
        imem_en_d = 1'b0;
        lat_cnt_d = CNT_W'(MEM_LATENCY - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        // enabled is deliberately ignored while a read is in flight.
        if (lat_cnt_q == '0) begin
          instr_d = imem_rdata;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = imem_addr_q;
  assign pc        = pc_q;
  assign instr_raw = instr_q;
  // A new start pulse withdraws completed in the same cycle.
  assign completed = done_q & ~enabled;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: two instances (ROM latency 1 and 3) share one stimulus
// stream; each has its own ROM pipeline and transaction-level expectation.
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          AW       = 14;
  localparam int          LAT [2]  = '{1, 3};

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        enabled = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = 32'h0;

  logic          imem_en_w   [2];
  logic [AW-1:0] imem_addr_w [2];
  logic [31:0]   rdata_w     [2];
  logic [31:0]   pc_w        [2];
  logic [31:0]   instr_w     [2];
  logic          completed_w [2];

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  fetch #(.RESET_PC(RESET_PC), .IMEM_AW(AW), .MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rstn(rstn), .enabled(enabled), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .imem_en(imem_en_w[0]), .imem_addr(imem_addr_w[0]),
    .imem_rdata(rdata_w[0]), .pc(pc_w[0]), .instr_raw(instr_w[0]),
    .completed(completed_w[0])
  );

  fetch #(.RESET_PC(RESET_PC), .IMEM_AW(AW), .MEM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rstn(rstn), .enabled(enabled), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .imem_en(imem_en_w[1]), .imem_addr(imem_addr_w[1]),
    .imem_rdata(rdata_w[1]), .pc(pc_w[1]), .instr_raw(instr_w[1]),
    .completed(completed_w[1])
  );

  // ROM contents: two fixed words, the rest a deterministic scramble.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    if (a == 0) return 32'h0050_0093;
    if (a == 1) return 32'h0000_0113;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // ROM: read issued when imem_en is high, data appears LAT cycles later.
  // Idle slots carry a marker so a mistimed capture is visible.
  logic [31:0] rom_pipe [2][4];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rom_pipe[k][0] <= imem_en_w[k] ? rom_word(imem_addr_w[k]) : (32'hBAD0_0000 | 32'(cycle[15:0]));
      for (int s = 1; s < 4; s++) rom_pipe[k][s] <= rom_pipe[k][s-1];
    end
  end
  assign rdata_w[0] = rom_pipe[0][LAT[0]-1];
  assign rdata_w[1] = rom_pipe[1][LAT[1]-1];

  // Transaction-level expectation: a fetch accepted when not busy, result
  // lands LAT+1 edges after acceptance.
  int          m_busy    [2];
  logic [31:0] m_fa      [2];
  logic [31:0] m_pc      [2];
  logic [31:0] m_pc_next [2];
  logic [31:0] m_instr   [2];
  logic        m_en      [2];
  logic [AW-1:0] m_addr  [2];
  logic        m_done    [2];

  function automatic logic [31:0] fa_of(input logic bt, input logic [31:0] bpc,
                                        input logic [31:0] seq);
    return bt ? (bpc & ~32'd3) : seq;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] <= 0;   m_fa[k] <= 32'h0;   m_pc[k] <= 32'h0;
        m_pc_next[k] <= RESET_PC;  m_instr[k] <= 32'h0000_0013;
        m_en[k] <= 1'b0;  m_addr[k] <= '0;    m_done[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k] == 0 && enabled) begin
          m_fa[k]      <= fa_of(branch_taken, branch_pc, m_pc_next[k]);
          m_pc[k]      <= fa_of(branch_taken, branch_pc, m_pc_next[k]);
          m_pc_next[k] <= fa_of(branch_taken, branch_pc, m_pc_next[k]) + 32'd4;
          m_addr[k]    <= AW'(fa_of(branch_taken, branch_pc, m_pc_next[k]) >> 2);
          m_en[k]      <= 1'b1;
          m_done[k]    <= 1'b0;
          m_busy[k]    <= LAT[k] + 1;
        end else if (m_busy[k] > 0) begin
          m_en[k] <= 1'b0;
          if (m_busy[k] == 1) begin
            m_instr[k] <= rom_word(AW'(m_fa[k] >> 2));
            m_done[k]  <= 1'b1;
          end
          m_busy[k] <= m_busy[k] - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the expectation.
  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("imem_en[L%0d]", LAT[k]),   32'(imem_en_w[k]),   32'(m_en[k]));
        check($sformatf("imem_addr[L%0d]", LAT[k]), 32'(imem_addr_w[k]), 32'(m_addr[k]));
        check($sformatf("pc[L%0d]", LAT[k]),        pc_w[k],             m_pc[k]);
        check($sformatf("instr[L%0d]", LAT[k]),     instr_w[k],          m_instr[k]);
        check($sformatf("completed[L%0d]", LAT[k]), 32'(completed_w[k]), 32'(m_done[k] & ~enabled));
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!(completed_w[0] && completed_w[1]) && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("completion_timeout", 32'(completed_w[0] && completed_w[1]), 32'd1);
  endtask

  task automatic do_fetch(input logic bt, input logic [31:0] bpc);
    @(posedge clk); #1 enabled = 1'b1; branch_taken = bt; branch_pc = bpc;
    @(posedge clk); #1 enabled = 1'b0; branch_taken = 1'($urandom); branch_pc = $urandom;
    wait_done();
  endtask

  initial begin
    int pulses;
    #2 rstn = 1'b0;
    #20;
    run_cmp = 1'b1;
    @(negedge clk);
    check("reset_instr", instr_w[0], 32'h0000_0013);
    check("reset_completed", 32'(completed_w[1]), 32'd0);
    #2 rstn = 1'b1;

    // Test 1: first fetch from RESET_PC, latency 1.
    @(posedge clk); #1 enabled = 1'b1;
    @(posedge clk); #1 enabled = 1'b0;                   // E0
    @(negedge clk);
    check("t1_en_req", 32'(imem_en_w[0]), 32'd1);
    @(negedge clk);                                      // after E1
    check("t1_en_off", 32'(imem_en_w[0]), 32'd0);
    check("t1_not_yet", 32'(completed_w[0]), 32'd0);
    @(negedge clk);                                      // after E2
    check("t1_completed", 32'(completed_w[0]), 32'd1);
    check("t1_pc", pc_w[0], 32'h0);
    check("t1_instr", instr_w[0], 32'h0050_0093);
    wait_done();

    // Test 2: sequential fetch.
    do_fetch(1'b0, 32'h0);
    check("t2_pc", pc_w[0], 32'h4);
    check("t2_instr", instr_w[1], 32'h0000_0113);
    check("t2_addr", 32'(imem_addr_w[0]), 32'd1);

    // Test 3: redirect with misaligned target, then sequential.
    do_fetch(1'b1, 32'h103);
    check("t3_pc", pc_w[1], 32'h100);
    check("t3_addr", 32'(imem_addr_w[0]), 32'h40);
    do_fetch(1'b0, 32'h0);
    check("t3_seq_pc", pc_w[0], 32'h104);

    // Test 4: re-pulse during WAIT is ignored (latency-3 instance).
    pulses = 0;
    @(posedge clk); #1 enabled = 1'b1;
    @(posedge clk); #1 enabled = 1'b0;                   // E0
    @(negedge clk); pulses += int'(imem_en_w[1]);
    @(posedge clk); #1 enabled = 1'b1; branch_taken = 1'b1; branch_pc = 32'h500;
    @(negedge clk); pulses += int'(imem_en_w[1]);
    @(posedge clk); #1 enabled = 1'b0; branch_taken = 1'b0;  // E2
    @(negedge clk); pulses += int'(imem_en_w[1]);
    @(negedge clk); pulses += int'(imem_en_w[1]);            // after E3
    check("t4_not_yet", 32'(completed_w[1]), 32'd0);
    @(negedge clk); pulses += int'(imem_en_w[1]);            // after E4
    check("t4_completed", 32'(completed_w[1]), 32'd1);
    check("t4_one_strobe", 32'(pulses), 32'd1);
    check("t4_pc", pc_w[1], 32'h108);
    wait_done();

    // Test 5: asynchronous reset while a read is in flight.
    @(posedge clk); #1 enabled = 1'b1;
    @(posedge clk); #1 enabled = 1'b0;                   // E0
    @(posedge clk); #3 rstn = 1'b0;                      // mid-cycle after E1
    #1;
    check("t5_completed", 32'(completed_w[0] | completed_w[1]), 32'd0);
    check("t5_instr", instr_w[1], 32'h0000_0013);
    #2 rstn = 1'b1;
    do_fetch(1'b0, 32'h0);
    check("t5_pc", pc_w[1], RESET_PC);
    check("t5_instr_after", instr_w[0], 32'h0050_0093);

    // Test 6: redirect to the top word, then wrap to zero.
    do_fetch(1'b1, 32'hFFFF_FFFC);
    check("t6_top_addr", 32'(imem_addr_w[1]), 32'h3FFF);
    do_fetch(1'b0, 32'h0000_0ABC);
    check("t6_wrap_pc", pc_w[0], 32'h0);
    check("t6_wrap_addr", 32'(imem_addr_w[1]), 32'h0);

    // Randomized phase, with occasional asynchronous resets.
    repeat (3000) begin
      @(posedge clk); #1;
      enabled      = ($urandom_range(0, 3) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       branch_pc = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        1:       branch_pc = 32'($urandom_range(0, 64));
        default: branch_pc = $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
      end
    end
    enabled = 1'b0;
    @(negedge clk);
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
